// File: rtl/calc_pkg.sv
// Shared constants for the stack calculator: instruction geometry, opcodes and
// the state encoding of the instruction queue loader.
package calc_pkg;

    localparam int INSTR_W         = 32;
    localparam int QUEUE_DEPTH     = 4;
    localparam int QPTR_W          = 2;
    localparam int BYTES_PER_INSTR = INSTR_W / 8;

    // Opcode lives in instr[31:28], i.e. the high nibble of the first byte received
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_MUL   = 4'h3;
    localparam logic [3:0] OP_DIV   = 4'h4;
    localparam logic [3:0] OP_MOD   = 4'h5;
    localparam logic [3:0] OP_PUSH  = 4'h6;
    localparam logic [3:0] OP_POP   = 4'h7;
    localparam logic [3:0] OP_SHIFT = 4'h8;
    localparam logic [3:0] OP_SETL  = 4'h9;
    localparam logic [3:0] OP_PRINT = 4'hA;
    localparam logic [3:0] OP_CLEAR = 4'hB;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } ldr_state_e;

endpackage

// File: rtl/instr_queue_loader_gap_timer.sv
// Inter-byte gap timer: down-counter reloaded on every accepted byte, pulses
// expired on the idle edge that exhausts the allowed gap. TIMEOUT_CYCLES=0 disables it.
module gap_timer #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LOAD_VAL = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (enable && (cnt_q != '0)) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    // A load on the same edge means a byte arrived: the byte wins over the timeout
    assign expired = (TIMEOUT_CYCLES != 0) && enable && !load && (cnt_q == '0);

endmodule

// File: rtl/instr_queue_loader.sv
// Packs a valid/ready byte stream MSB-first into 32-bit instructions and writes
// them into the 4-entry ring read by the calculator core; owns the write head.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_COLLECT | accepting bytes; 4th byte is written straight into the ring
// ST_HOLD    | complete word parked while the ring is full; byte_ready low
module instr_queue_loader
    import calc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    output logic                byte_ready,
    output logic [INSTR_W-1:0]  instr_queue [QUEUE_DEPTH-1:0],
    output logic [QPTR_W-1:0]   queue_write_head,
    input  logic [QPTR_W-1:0]   queue_read_head,
    output logic                queue_full,
    output logic                frame_error,
    output logic [CNT_W-1:0]    instr_count
);

    ldr_state_e          state_q, state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [INSTR_W-1:0]  word_q, word_d;
    logic [QPTR_W-1:0]   write_head_q, write_head_d;
    logic [CNT_W-1:0]    instr_count_q, instr_count_d;
    logic                frame_error_q, frame_error_d;
    logic [INSTR_W-1:0]  instr_queue_q [QUEUE_DEPTH-1:0];
    logic [INSTR_W-1:0]  instr_queue_d [QUEUE_DEPTH-1:0];

    logic                byte_accept;
    logic                gap_load;
    logic                gap_enable;
    logic                gap_expired;
    logic                wr_en;
    logic [INSTR_W-1:0]  wr_data;
    logic [INSTR_W-1:0]  word_next;
    logic [QPTR_W-1:0]   head_inc;

    gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (gap_load),
        .enable  (gap_enable),
        .expired (gap_expired)
    );

    assign head_inc   = write_head_q + QPTR_W'(1);
    assign queue_full = (head_inc == queue_read_head);
    assign word_next  = {word_q[INSTR_W-9:0], byte_data};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_COLLECT;
            byte_cnt_q    <= '0;
            word_q        <= '0;
            write_head_q  <= '0;
            instr_count_q <= '0;
            frame_error_q <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                instr_queue_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            byte_cnt_q    <= byte_cnt_d;
            word_q        <= word_d;
            write_head_q  <= write_head_d;
            instr_count_q <= instr_count_d;
            frame_error_q <= frame_error_d;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                instr_queue_q[i] <= instr_queue_d[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        word_d        = word_q;
        write_head_d  = write_head_q;
        instr_count_d = instr_count_q;
        frame_error_d = gap_expired;
        gap_load      = 1'b0;
        wr_en         = 1'b0;
        wr_data       = word_next;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            instr_queue_d[i] = instr_queue_q[i];
        end

        case (state_q)
            ST_COLLECT: begin
                if (byte_accept) begin
                    gap_load = 1'b1;
                    word_d   = word_next;
                    if (byte_cnt_q == 2'd3) begin
                        if (!queue_full) begin
                            wr_en      = 1'b1;
                            byte_cnt_d = '0;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end else if (gap_expired) begin
                    byte_cnt_d = '0;
                    word_d     = '0;
                end
            end
            ST_HOLD: begin
                if (!queue_full) begin
                    wr_en      = 1'b1;
                    wr_data    = word_q;
                    byte_cnt_d = '0;
                    state_d    = ST_COLLECT;
                end
            end
            default: state_d = ST_COLLECT;
        endcase

        // Only the slot at the write head is ever touched
        if (wr_en) begin
            instr_queue_d[write_head_q] = wr_data;
            write_head_d                = head_inc;
            instr_count_d               = instr_count_q + CNT_W'(1);
        end
    end

    always_comb begin
        byte_ready  = (state_q == ST_COLLECT);
        byte_accept = byte_valid && byte_ready;
        gap_enable  = (state_q == ST_COLLECT) && (byte_cnt_q != 2'd0);
    end

    assign queue_write_head = write_head_q;
    assign frame_error      = frame_error_q;
    assign instr_count      = instr_count_q;
    assign instr_queue      = instr_queue_q;

endmodule

// File: tb/tb_instr_queue_loader.sv
// Directed and scoreboarded bench for instr_queue_loader with a short gap timeout.
module tb_instr_queue_loader;
    import calc_pkg::*;

    localparam int CLK_PERIOD = 10;
    localparam int TMO        = 8;
    localparam int NW         = 40;

    logic               clk;
    logic               rst_n;
    logic               byte_valid;
    logic [7:0]         byte_data;
    logic               byte_ready;
    logic [INSTR_W-1:0] iq [QUEUE_DEPTH-1:0];
    logic [QPTR_W-1:0]  whead;
    logic [QPTR_W-1:0]  rhead;
    logic               qfull;
    logic               ferr;
    logic [15:0]        icount;

    int checks = 0;
    int errors = 0;

    instr_queue_loader #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .byte_valid       (byte_valid),
        .byte_data        (byte_data),
        .byte_ready       (byte_ready),
        .instr_queue      (iq),
        .queue_write_head (whead),
        .queue_read_head  (rhead),
        .queue_full       (qfull),
        .frame_error      (ferr),
        .instr_count      (icount)
    );

    initial clk = 1'b0;
    always #(CLK_PERIOD / 2) clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic [1:0]  rh;
        logic        e_rdy;
        logic [1:0]  e_head;
        logic        e_full;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(logic v, logic [7:0] d, logic [1:0] rh,
                                logic e_rdy, logic [1:0] e_head, logic e_full, logic [15:0] e_cnt);
        vec_t r;
        r.v = v; r.d = d; r.rh = rh;
        r.e_rdy = e_rdy; r.e_head = e_head; r.e_full = e_full; r.e_cnt = e_cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            send(t[31:24]);
            t = t << 8;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        rhead      = 2'd0;
        #(CLK_PERIOD * 2);
        rst_n = 1'b1;
    endtask

    // Random stream with a core model that consumes entries in order
    task automatic random_run();
        logic [31:0] exp_q [$];
        logic [31:0] asm_w;
        logic [7:0]  pb;
        logic        pend;
        logic        acc;
        int          nb;
        int          sent;
        int          idle;
        int          cyc;
        asm_w = '0; pb = '0; pend = 1'b0; nb = 0; sent = 0; idle = 0; cyc = 0;
        while ((sent < NW * 4 || exp_q.size() > 0) && cyc < 6000) begin
            if (rhead != whead && $urandom_range(0, 2) != 0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_spurious: got %h expected none", iq[rhead]);
                end else begin
                    chk("rand_read", iq[rhead], exp_q.pop_front());
                end
                rhead = rhead + 2'd1;
            end
            if (!pend && sent < NW * 4) begin
                if (idle >= 3 || $urandom_range(0, 1) == 0) begin
                    pend = 1'b1;
                    pb   = 8'($urandom_range(0, 255));
                end else begin
                    idle++;
                end
            end
            byte_valid = pend;
            byte_data  = pb;
            acc        = pend && byte_ready;
            step();
            cyc++;
            if (acc) begin
                asm_w = {asm_w[23:0], pb};
                nb++;
                sent++;
                pend = 1'b0;
                idle = 0;
                if (nb == 4) begin
                    exp_q.push_back(asm_w);
                    nb = 0;
                end
            end
        end
        byte_valid = 1'b0;
        if (cyc >= 6000) begin
            checks++;
            errors++;
            $display("FAIL rand_timeout: got %0d words pending expected 0", exp_q.size());
        end
        chk("rand_count", 32'(icount), 32'(NW));
        chk("rand_ferr", 32'(ferr), 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        rhead      = 2'd0;

        tbl[0]  = mk(1, 8'h10, 0, 1, 0, 0, 0);
        tbl[1]  = mk(1, 8'h00, 0, 1, 0, 0, 0);
        tbl[2]  = mk(1, 8'h00, 0, 1, 0, 0, 0);
        tbl[3]  = mk(1, 8'h21, 0, 1, 1, 0, 1);
        tbl[4]  = mk(1, 8'h22, 0, 1, 1, 0, 1);
        tbl[5]  = mk(1, 8'h00, 0, 1, 1, 0, 1);
        tbl[6]  = mk(1, 8'h00, 0, 1, 1, 0, 1);
        tbl[7]  = mk(1, 8'h05, 0, 1, 2, 0, 2);
        tbl[8]  = mk(1, 8'h33, 0, 1, 2, 0, 2);
        tbl[9]  = mk(1, 8'h00, 0, 1, 2, 0, 2);
        tbl[10] = mk(1, 8'h00, 0, 1, 2, 0, 2);
        tbl[11] = mk(1, 8'h07, 0, 1, 3, 1, 3);
        tbl[12] = mk(1, 8'h44, 0, 1, 3, 1, 3);
        tbl[13] = mk(1, 8'h00, 0, 1, 3, 1, 3);
        tbl[14] = mk(1, 8'h00, 0, 1, 3, 1, 3);
        tbl[15] = mk(1, 8'h09, 0, 0, 3, 1, 3);
        tbl[16] = mk(1, 8'h55, 0, 0, 3, 1, 3);
        tbl[17] = mk(0, 8'h00, 1, 1, 0, 1, 4);
        tbl[18] = mk(0, 8'h00, 2, 1, 0, 0, 4);

        // Reset state
        do_reset();
        chk("rst_ready", 32'(byte_ready), 32'd1);
        chk("rst_head", 32'(whead), 32'd0);
        chk("rst_full", 32'(qfull), 32'd0);
        chk("rst_count", 32'(icount), 32'd0);
        chk("rst_ferr", 32'(ferr), 32'd0);
        for (int i = 0; i < QUEUE_DEPTH; i++) chk("rst_entry", iq[i], 32'd0);

        // Single word, fill-to-full, HOLD and release
        for (int i = 0; i < 19; i++) begin
            byte_valid = tbl[i].v;
            byte_data  = tbl[i].d;
            rhead      = tbl[i].rh;
            step();
            chk($sformatf("vec%0d_ready", i), 32'(byte_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_head", i), 32'(whead), 32'(tbl[i].e_head));
            chk($sformatf("vec%0d_full", i), 32'(qfull), 32'(tbl[i].e_full));
            chk($sformatf("vec%0d_count", i), 32'(icount), 32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_ferr", i), 32'(ferr), 32'd0);
        end
        byte_valid = 1'b0;
        chk("ring0", iq[0], 32'h10000021);
        chk("ring1", iq[1], 32'h22000005);
        chk("ring2", iq[2], 32'h33000007);
        chk("ring3", iq[3], 32'h44000009);

        // Gap timeout discards the partial word
        do_reset();
        send(8'hAA);
        send(8'hBB);
        for (int i = 0; i < TMO - 1; i++) begin
            step();
            chk("tmo_early_ferr", 32'(ferr), 32'd0);
        end
        step();
        chk("tmo_ferr_pulse", 32'(ferr), 32'd1);
        step();
        chk("tmo_ferr_clear", 32'(ferr), 32'd0);
        send_word(32'h01020304);
        chk("tmo_entry", iq[0], 32'h01020304);
        chk("tmo_head", 32'(whead), 32'd1);
        chk("tmo_count", 32'(icount), 32'd1);

        // Byte on the exact timeout edge wins
        send(8'hCC);
        for (int i = 0; i < TMO - 1; i++) step();
        send(8'hDD);
        chk("edge_ferr", 32'(ferr), 32'd0);
        send(8'hEE);
        send(8'hFF);
        chk("edge_entry", iq[1], 32'hCCDDEEFF);
        chk("edge_head", 32'(whead), 32'd2);

        // Async reset while holding a word
        send_word(32'h11223344);
        send_word(32'h55667788);
        chk("hold_ready", 32'(byte_ready), 32'd0);
        chk("hold_head", 32'(whead), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_head", 32'(whead), 32'd0);
        chk("arst_ready", 32'(byte_ready), 32'd1);
        chk("arst_full", 32'(qfull), 32'd0);
        chk("arst_count", 32'(icount), 32'd0);
        chk("arst_entry3", iq[3], 32'd0);
        #(CLK_PERIOD);
        rst_n = 1'b1;
        step();
        send_word(32'hDEADBEEF);
        chk("arst_slot0", iq[0], 32'hDEADBEEF);
        chk("arst_head_after", 32'(whead), 32'd1);

        // Random traffic against an in-order scoreboard
        do_reset();
        random_run();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
